// File: rtl/quiz_answer_ctrl_pkg.sv
// Shared definitions for the quiz round controller: state encoding,
// winner index width, default timing constants and a counter-width helper.
package quiz_answer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_BEEP_A = 3'd2,
        ST_BEEP_T = 3'd3,
        ST_DONE   = 3'd4
    } quiz_state_e;

    localparam int WINNER_W = 3;

    localparam int DEF_N_PLAYERS   = 4;
    localparam int DEF_TICK_DIV    = 50000000;
    localparam int DEF_ANSWER_SEC  = 10;
    localparam int DEF_BEEP_CYCLES = 25000000;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/quiz_answer_ctrl_sec_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and pulses
// tick_o for one cycle on the last count. clr_i forces the count to 0.
module sec_tick_gen
    import quiz_answer_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and tick pulse; clear wins over enable.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            tick_o = (cnt_q == LAST);
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/quiz_answer_ctrl.sv
// Quiz round controller: arms a round on a Start rise, latches the first
// contestant key rise, counts the answer window down in seconds and holds
// the answer / time-over buzzer requests high for BEEP_CYCLES cycles.
// Optional macro QUIZ_FALSE_START_EN: a key rise while IDLE is a foul.
// Dbg_State exposes the FSM state for observation.
module quiz_answer_ctrl
    import quiz_answer_ctrl_pkg::*;
#(
    parameter int N_PLAYERS   = DEF_N_PLAYERS,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int ANSWER_SEC  = DEF_ANSWER_SEC,
    parameter int BEEP_CYCLES = DEF_BEEP_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    input  logic                 Clear,
    input  logic [N_PLAYERS-1:0] Key,
    output logic [2:0]           Winner_ID,
    output logic                 Winner_Valid,
    output logic                 Foul,
    output logic [7:0]           Sec_Left,
    output logic                 Busy,
    output logic                 Buzzer_Answer,
    output logic                 Buzzer_TimeOver,
    output logic [2:0]           Dbg_State
);

    localparam int BW = cnt_width(BEEP_CYCLES);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

    quiz_state_e state_q, state_d;

    logic [N_PLAYERS-1:0] key_prev_q;
    logic                 start_prev_q;
    logic [N_PLAYERS-1:0] key_rise;
    logic                 start_rise;
    logic                 rise_any;
    logic [WINNER_W-1:0]  rise_id;

    logic [WINNER_W-1:0]  win_id_q, win_id_d;
    logic                 win_vld_q, win_vld_d;
    logic [7:0]           sec_q, sec_d;
    logic [BW-1:0]        beep_cnt_q, beep_cnt_d;
    logic                 buz_a_q, buz_t_q;
    logic                 tick;
`ifdef QUIZ_FALSE_START_EN
    logic                 foul_q, foul_d;
`endif

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (Clear || (state_q != ST_ARMED)),
        .en_i   (state_q == ST_ARMED),
        .tick_o (tick)
    );

    // Edge-detect history; sampled every cycle, even in reset, so a key
    // held through reset or clear never looks like a fresh press.
    always_ff @(posedge CLK) begin
        key_prev_q   <= Key;
        start_prev_q <= Start;
    end

    assign key_rise   = Key & ~key_prev_q;
    assign start_rise = Start & ~start_prev_q;
    assign rise_any   = |key_rise;

    // Lowest index among simultaneous key rises.
    always_comb begin
        rise_id = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (key_rise[i]) rise_id = WINNER_W'(i);
        end
    end

    // Next-state and datapath updates; Clear returns everything to IDLE.
    always_comb begin
        state_d    = state_q;
        win_id_d   = win_id_q;
        win_vld_d  = win_vld_q;
        sec_d      = sec_q;
        beep_cnt_d = '0;
`ifdef QUIZ_FALSE_START_EN
        foul_d     = foul_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef QUIZ_FALSE_START_EN
                if (rise_any) begin
                    state_d   = ST_BEEP_T;
                    win_id_d  = rise_id;
                    win_vld_d = 1'b1;
                    foul_d    = 1'b1;
                end else if (start_rise) begin
                    state_d = ST_ARMED;
                    sec_d   = 8'(ANSWER_SEC);
                end
`else
                if (start_rise) begin
                    state_d = ST_ARMED;
                    sec_d   = 8'(ANSWER_SEC);
                end
`endif
            end
            ST_ARMED: begin
                // A press in the final-tick cycle beats the timeout.
                if (rise_any) begin
                    state_d   = ST_BEEP_A;
                    win_id_d  = rise_id;
                    win_vld_d = 1'b1;
                end else if (tick) begin
                    if (sec_q == 8'd1) begin
                        sec_d   = 8'd0;
                        state_d = ST_BEEP_T;
                    end else begin
                        sec_d = sec_q - 8'd1;
                    end
                end
            end
            ST_BEEP_A, ST_BEEP_T: begin
                if (beep_cnt_q == BEEP_LAST) state_d = ST_DONE;
                else                         beep_cnt_d = beep_cnt_q + 1'b1;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (Clear) begin
            state_d    = ST_IDLE;
            win_id_d   = '0;
            win_vld_d  = 1'b0;
            sec_d      = 8'd0;
            beep_cnt_d = '0;
`ifdef QUIZ_FALSE_START_EN
            foul_d     = 1'b0;
`endif
        end
    end

    // State, datapath and buzzer registers; buzzers follow the next state
    // so they rise together with the state change into a beep phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            win_id_q   <= '0;
            win_vld_q  <= 1'b0;
            sec_q      <= 8'd0;
            beep_cnt_q <= '0;
            buz_a_q    <= 1'b0;
            buz_t_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_id_q   <= win_id_d;
            win_vld_q  <= win_vld_d;
            sec_q      <= sec_d;
            beep_cnt_q <= beep_cnt_d;
            buz_a_q    <= (state_d == ST_BEEP_A);
            buz_t_q    <= (state_d == ST_BEEP_T);
        end
    end

`ifdef QUIZ_FALSE_START_EN
    // Foul flag register.
    always_ff @(posedge CLK) begin
        if (RST) foul_q <= 1'b0;
        else     foul_q <= foul_d;
    end
    assign Foul = foul_q;
`else
    assign Foul = 1'b0;
`endif

    assign Winner_ID       = win_id_q;
    assign Winner_Valid    = win_vld_q;
    assign Sec_Left        = sec_q;
    assign Busy            = (state_q != ST_IDLE);
    assign Buzzer_Answer   = buz_a_q;
    assign Buzzer_TimeOver = buz_t_q;
    assign Dbg_State       = state_q;

endmodule

// File: tb/tb_quiz_answer_ctrl.sv
// Directed bench for quiz_answer_ctrl with N_PLAYERS=4, TICK_DIV=10,
// ANSWER_SEC=3, BEEP_CYCLES=5. Honours QUIZ_FALSE_START_EN.
module tb_quiz_answer_ctrl;

  localparam int NP = 4;
  localparam logic [31:0] S_IDLE  = 32'd0;
  localparam logic [31:0] S_ARMED = 32'd1;
  localparam logic [31:0] S_DONE  = 32'd4;

  // clock / reset / stimulus signals
  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic          Clear;
  logic [NP-1:0] Key;
  logic [2:0]    Winner_ID;
  logic          Winner_Valid;
  logic          Foul;
  logic [7:0]    Sec_Left;
  logic          Busy;
  logic          Buzzer_Answer;
  logic          Buzzer_TimeOver;
  logic [2:0]    Dbg_State;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  quiz_answer_ctrl #(
    .N_PLAYERS(NP), .TICK_DIV(10), .ANSWER_SEC(3), .BEEP_CYCLES(5)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Clear(Clear), .Key(Key),
    .Winner_ID(Winner_ID), .Winner_Valid(Winner_Valid), .Foul(Foul),
    .Sec_Left(Sec_Left), .Busy(Busy), .Buzzer_Answer(Buzzer_Answer),
    .Buzzer_TimeOver(Buzzer_TimeOver), .Dbg_State(Dbg_State)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance n clock edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_wid"}, 32'(Winner_ID), 0);
    check({tag, "_wvld"}, 32'(Winner_Valid), 0);
    check({tag, "_foul"}, 32'(Foul), 0);
    check({tag, "_sec"}, 32'(Sec_Left), 0);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_ba"}, 32'(Buzzer_Answer), 0);
    check({tag, "_bt"}, 32'(Buzzer_TimeOver), 0);
    check({tag, "_st"}, 32'(Dbg_State), S_IDLE);
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
  endtask

  task automatic clear_pulse();
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
  endtask

  // invariants sampled on the falling edge
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      check("excl_buzz", 32'(Buzzer_Answer & Buzzer_TimeOver), 0);
      check("wid_when_invalid", Winner_Valid ? 32'd0 : 32'(Winner_ID), 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sec;
    RST = 1'b1; Start = 1'b0; Clear = 1'b0; Key = '0;
    step(2);
    check_idle("reset");
    RST = 1'b0;

    // 1: Key[2] rises 7 cycles after Start
    start_pulse();
    check("t1_busy", 32'(Busy), 1);
    check("t1_sec0", 32'(Sec_Left), 3);
    check("t1_armed", 32'(Dbg_State), S_ARMED);
    step(6);
    Key = 4'b0100;
    step(1);
    check("t1_wid", 32'(Winner_ID), 2);
    check("t1_wvld", 32'(Winner_Valid), 1);
    check("t1_ba", 32'(Buzzer_Answer), 1);
    check("t1_bt", 32'(Buzzer_TimeOver), 0);
    check("t1_sec", 32'(Sec_Left), 3);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t1_ba_hold", 32'(Buzzer_Answer), 1);
    end
    step(1);
    check("t1_ba_end", 32'(Buzzer_Answer), 0);
    check("t1_done", 32'(Dbg_State), S_DONE);
    check("t1_done_wid", 32'(Winner_ID), 2);
    check("t1_done_wvld", 32'(Winner_Valid), 1);
    check("t1_done_sec", 32'(Sec_Left), 3);
    check("t1_done_busy", 32'(Busy), 1);
    Key = '0;
    start_pulse();
    step(1);
    check("t1_start_in_done", 32'(Dbg_State), S_DONE);
    check("t1_done_ba", 32'(Buzzer_Answer), 0);
    clear_pulse();
    check_idle("t1_clear");

    // 2: no keys, full countdown and timeout
    start_pulse();
    for (int c = 1; c <= 36; c++) begin
      step(1);
      exp_sec = (c < 10) ? 3 : (c < 20) ? 2 : (c < 30) ? 1 : 0;
      check("t2_sec", 32'(Sec_Left), 32'(exp_sec));
      check("t2_bt", 32'(Buzzer_TimeOver), (c >= 30 && c < 35) ? 32'd1 : 32'd0);
      check("t2_ba", 32'(Buzzer_Answer), 0);
      check("t2_wvld", 32'(Winner_Valid), 0);
    end
    check("t2_done", 32'(Dbg_State), S_DONE);
    clear_pulse();

    // 3: simultaneous Key[1] and Key[3]; later Key[0] ignored
    start_pulse();
    step(3);
    Key = 4'b1010;
    step(1);
    check("t3_wid", 32'(Winner_ID), 1);
    check("t3_ba", 32'(Buzzer_Answer), 1);
    Key = 4'b1011;
    step(1);
    check("t3_wid_late", 32'(Winner_ID), 1);
    step(4);
    check("t3_done", 32'(Dbg_State), S_DONE);
    check("t3_done_wid", 32'(Winner_ID), 1);
    check("t3_done_ba", 32'(Buzzer_Answer), 0);
    Key = '0;
    clear_pulse();

    // 4: Key[0] rises in the final-tick cycle
    start_pulse();
    step(29);
    check("t4_sec_pre", 32'(Sec_Left), 1);
    Key = 4'b0001;
    step(1);
    check("t4_ba", 32'(Buzzer_Answer), 1);
    check("t4_bt", 32'(Buzzer_TimeOver), 0);
    check("t4_wid", 32'(Winner_ID), 0);
    check("t4_wvld", 32'(Winner_Valid), 1);
    check("t4_sec", 32'(Sec_Left), 1);
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t4_bt_never", 32'(Buzzer_TimeOver), 0);
    end
    check("t4_done", 32'(Dbg_State), S_DONE);
    Key = '0;
    clear_pulse();

    // 5a: Key[3] held across reset and Start never wins
    Key = 4'b1000;
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    start_pulse();
    step(5);
    check("t5_armed", 32'(Dbg_State), S_ARMED);
    check("t5_wvld", 32'(Winner_Valid), 0);
    step(25);
    check("t5_bt", 32'(Buzzer_TimeOver), 1);
    check("t5_sec", 32'(Sec_Left), 0);
    check("t5_wvld_to", 32'(Winner_Valid), 0);
    Key = '0;
    clear_pulse();
    step(1);

    // 5b: Clear in the middle of BEEP_A
    start_pulse();
    step(2);
    Key = 4'b0010;
    step(1);
    check("t5b_ba", 32'(Buzzer_Answer), 1);
    step(2);
    clear_pulse();
    check_idle("t5b_clear");
    Key = '0;
    step(2);

    // 6: key rise while IDLE
    Key = 4'b0100;
    step(1);
`ifdef QUIZ_FALSE_START_EN
    check("t6_foul", 32'(Foul), 1);
    check("t6_wid", 32'(Winner_ID), 2);
    check("t6_wvld", 32'(Winner_Valid), 1);
    check("t6_bt", 32'(Buzzer_TimeOver), 1);
    check("t6_sec", 32'(Sec_Left), 0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t6_bt_hold", 32'(Buzzer_TimeOver), 1);
    end
    step(1);
    check("t6_bt_end", 32'(Buzzer_TimeOver), 0);
    check("t6_done", 32'(Dbg_State), S_DONE);
    check("t6_done_foul", 32'(Foul), 1);
`else
    for (int i = 0; i < 3; i++) begin
      check("t6_busy", 32'(Busy), 0);
      check("t6_wvld", 32'(Winner_Valid), 0);
      check("t6_foul", 32'(Foul), 0);
      check("t6_bt", 32'(Buzzer_TimeOver), 0);
      step(1);
    end
`endif
    Key = '0;
    clear_pulse();
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quiz_answer_ctrl.md
Name: quiz_answer_ctrl

Overview:
- Round controller for the quiz responder. Sits directly upstream of the buzzer driver.
- Arms a round on a host Start, latches the first contestant to press, and counts down the answer window in seconds.
- Drives Buzzer_Answer when a contestant wins the press. Drives Buzzer_TimeOver when the window expires.
- Both buzzer outputs are level signals held for BEEP_CYCLES, because the buzzer driver only tones while its input is held high.

Parameters:
- N_PLAYERS, 4: number of contestant keys, 2..8.
- TICK_DIV, 50000000: CLK cycles per one-second tick.
- ANSWER_SEC, 10: countdown start value in seconds, 1..255.
- BEEP_CYCLES, 25000000: cycles each buzzer output is held high.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  host start, rising-edge detected.
- Clear  in  1  host round clear, level, synchronous.
- Key  in  N_PLAYERS  contestant keys, active-high, already debounced and synchronous to CLK.
- Winner_ID  out  3  index of the latched winner.
- Winner_Valid  out  1  winner latched.
- Foul  out  1  winner pressed before start (see Optional Feature).
- Sec_Left  out  8  seconds remaining.
- Busy  out  1  high when not IDLE.
- Buzzer_Answer  out  1  answer tone request.
- Buzzer_TimeOver  out  1  timeout tone request.

Behaviour:
- Reset and Clear: on RST (synchronous, active-high), and on Clear in any state, the following apply on the next cycle:
  - State goes to IDLE.
  - All outputs go to 0.
  - Tick and beep counters go to 0.
  - RST has priority over Clear.
- Edge detect: Key_d and Start_d are registered every cycle, including IDLE. A rise is the current value high with the previous value low. A key already held when the round arms never wins without a fresh rise.
- IDLE:
  - Start rise -> ARMED.
  - Sec_Left is loaded with ANSWER_SEC and the tick counter is cleared.
  - Busy=1 from the next cycle.
- ARMED:
  - The tick counter counts 0..TICK_DIV-1 and wraps.
  - At each wrap, Sec_Left decrements by 1.
  - If Sec_Left==1 at the wrap: Sec_Left goes to 0 and the state goes to BEEP_T.
  - Key rise seen in cycle k:
    - Winner_ID is set to the lowest index among simultaneous rises.
    - Winner_Valid=1 and Buzzer_Answer=1 from cycle k+1.
    - State goes to BEEP_A. Sec_Left freezes.
  - Key rise and final tick in the same cycle: the key wins and no TimeOver is raised.
  - Start while ARMED is ignored.
- BEEP_A and BEEP_T:
  - The beep counter counts BEEP_CYCLES cycles.
  - Buzzer_Answer (BEEP_A) or Buzzer_TimeOver (BEEP_T) is high for exactly BEEP_CYCLES cycles.
  - State then goes to DONE.
  - Key rises are ignored.
- DONE:
  - Winner_ID, Winner_Valid, Foul and Sec_Left are held.
  - Both buzzer outputs are 0.
  - Only Clear leaves DONE. Start is ignored.
- Invariants:
  - Buzzer_Answer and Buzzer_TimeOver are never high in the same cycle.
  - Winner_ID is 0 whenever Winner_Valid=0.
- Counter widths: sized by $clog2 of TICK_DIV and BEEP_CYCLES. No overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: QUIZ_FALSE_START_EN.
- Defined:
  - A Key rise in IDLE latches Winner_ID (lowest index) with Winner_Valid=1 and Foul=1.
  - The state goes to BEEP_T, so Buzzer_TimeOver is held for BEEP_CYCLES.
  - Then DONE. Sec_Left stays 0.
  - A Start rise in the same cycle as the key rise loses to the foul.
- Undefined:
  - IDLE key rises are ignored.
  - The Foul port remains and is tied to 0.

Decomposition:
- Shared quiz_defs package/include holds:
  - State encodings: IDLE, ARMED, BEEP_A, BEEP_T, DONE.
  - Winner_ID width constant.
  - Default timing constants.
- One natural sub-module, sec_tick_gen: the prescaler, with enable and clear inputs and a one-cycle tick output. The buzzer-hold counter stays inline.

Test Plan (N_PLAYERS=4, TICK_DIV=10, ANSWER_SEC=3, BEEP_CYCLES=5):
- Start pulse, Key[2] rises 7 cycles later -> next cycle: Winner_ID=2, Winner_Valid=1, Buzzer_Answer high for 5 cycles, Sec_Left=3; then DONE with outputs held.
- Start, no keys -> Sec_Left 3,2,1 at 10-cycle ticks; on the 3rd tick Sec_Left=0 and Buzzer_TimeOver high for 5 cycles; Winner_Valid=0.
- Key[1] and Key[3] rise in the same cycle while ARMED -> Winner_ID=1; later rises on Key[0] are ignored.
- Key[0] rises in the same cycle as the final tick -> Buzzer_Answer asserted, Buzzer_TimeOver never asserted.
- Key[3] held high before Start and still held -> no winner; the round times out. Clear asserted mid-BEEP_A -> next cycle all outputs 0, IDLE.
- With QUIZ_FALSE_START_EN, Key[2] rises in IDLE -> Foul=1, Winner_ID=2, Buzzer_TimeOver high for 5 cycles; without the macro -> no response, Busy=0.
